i2c_cmd_sequencer: RTL and testbench

- Command front-end directly upstream of the I2C master. Buffers host I2C transactions (7-bit address, 8-bit data, rd/wr) in a small FIFO.
- Presents one transaction at a time on the master's addr/data/rd_wr/enable inputs. Tracks the master's ready handshake to completion.
- Returns one response per command (read data or error) to the host over a valid/ready handshake.

---
 rtl/i2c_cmd_sequencer_if.sv | 39 +++
 rtl/i2c_cmd_sequencer.sv | 141 ++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_sequencer_if.sv
// Host command/response and I2C master-side signals of the command sequencer.
// The sequencer takes the slave side; the host/master model takes the master side.
interface i2c_cmd_sequencer_if #(
  parameter int LW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [6:0]    cmd_addr;
  logic [7:0]    cmd_data;
  logic          cmd_rd_wr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [7:0]    rsp_data;
  logic          rsp_err;
  logic [6:0]    m_addr;
  logic [7:0]    m_data;
  logic          m_rd_wr;
  logic          m_enable;
  logic          m_ready;
  logic [7:0]    m_data_out;
  logic          busy;
  logic [LW-1:0] level;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, cmd_rd_wr,
    input  rsp_ready, m_ready, m_data_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output m_addr, m_data, m_rd_wr, m_enable,
    output busy, level
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_data, cmd_rd_wr,
    output rsp_ready, m_ready, m_data_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  m_addr, m_data, m_rd_wr, m_enable,
    input  busy, level
  );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Buffers host I2C commands, issues them one at a time to the I2C master
// and returns one response (read data or timeout error) per command.
module i2c_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input logic clk,
  input logic rst,
  i2c_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          sync1;
  logic          sync2;
  logic [TW-1:0] timer;
  logic [6:0]    m_addr;
  logic [7:0]    m_data;
  logic          m_rd_wr;
  logic          m_enable;
  logic          rsp_valid;
  logic          rsp_err;
  logic [7:0]    rsp_data;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic tmax;
  logic accept;
  logic done_ok;
  logic abort;

  assign full  = cnt == LW'(DEPTH);
  assign empty = cnt == '0;
  assign push  = bus.cmd_valid && !full;
  // A pending response blocks issue so rsp_valid can never be re-set.
  assign pop   = state == IDLE && !empty && !rsp_valid;
  assign tmax  = timer == TW'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (pop) state_n = ISSUE;
      ISSUE:     if (!sync2) state_n = WAIT_DONE;
                 else if (tmax) state_n = IDLE;
      WAIT_DONE: if (sync2 || tmax) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    done_ok = 1'b0;
    abort   = 1'b0;
    unique case (state)
      ISSUE: begin
        accept = !sync2;
        abort  = sync2 && tmax;
      end
      WAIT_DONE: begin
        done_ok = sync2;
        abort   = !sync2 && tmax;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_rd_wr, bus.cmd_addr, bus.cmd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      timer     <= '0;
      m_addr    <= '0;
      m_data    <= '0;
      m_rd_wr   <= 1'b0;
      m_enable  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      sync1 <= bus.m_ready;
      sync2 <= sync1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + LW'(push) - LW'(pop);
      if (pop) begin
        {m_rd_wr, m_addr, m_data} <= mem[rd_ptr];
        m_enable <= 1'b1;
      end else if (accept || abort) begin
        m_enable <= 1'b0;
      end
      if (pop || accept) timer <= '0;
      else if (state != IDLE && !done_ok && !abort) timer <= timer + 1'b1;
      if (done_ok || abort) begin
        rsp_valid <= 1'b1;
        rsp_err   <= abort;
        rsp_data  <= (done_ok && m_rd_wr) ? bus.m_data_out : 8'h00;
      end else if (rsp_valid && bus.rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = !full;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_data  = rsp_data;
  assign bus.m_addr    = m_addr;
  assign bus.m_data    = m_data;
  assign bus.m_rd_wr   = m_rd_wr;
  assign bus.m_enable  = m_enable;
  assign bus.busy      = state != IDLE;
  assign bus.level     = cnt;
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer: directed commands, a behavioural
// I2C master and a response monitor checking against queued expectations.
module tb_i2c_cmd_sequencer;
  localparam int LOW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mode = 0;
  logic [8:0] sb[$];

  i2c_cmd_sequencer_if #(.LW(3)) bus ();

  i2c_cmd_sequencer #(
    .DEPTH(4),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [6:0] a, input logic [7:0] d,
                      input logic rw, output logic ok);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    bus.cmd_rd_wr = rw;
    ok = bus.cmd_ready;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input logic lvl, input string name);
    int n = 0;
    while (bus.m_enable !== lvl && n < 100) begin
      cyc(1);
      n++;
    end
    chk(name, bus.m_enable, lvl);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(bus.busy == 0 && bus.rsp_valid == 0 && bus.level == 0
             && sb.size() == 0) && n < 400) begin
      cyc(1);
      n++;
    end
    chk(name, {bus.busy, bus.rsp_valid, bus.level, sb.size() == 0},
        {1'b0, 1'b0, 3'd0, 1'b1});
  endtask

  // Master: drops ready 3 cycles after enable, raises it LOW cycles later.
  initial begin
    int md;
    bus.m_ready    = 1'b1;
    bus.m_data_out = 8'h00;
    forever begin
      cyc(1);
      if (bus.m_enable) begin
        md = mode;
        if (md == 1) begin
          while (bus.m_enable) cyc(1);
        end else begin
          cyc(3);
          bus.m_ready = 1'b0;
          if (md == 0) begin
            cyc(LOW);
            bus.m_data_out = {1'b0, bus.m_addr} ^ 8'h42;
            bus.m_ready = 1'b1;
          end else begin
            while (!bus.rsp_valid) cyc(1);
            bus.m_ready = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: got %0h expected none",
                   {bus.rsp_err, bus.rsp_data});
        end else begin
          e = sb.pop_front();
          chk("rsp", {bus.rsp_err, bus.rsp_data}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    int   n;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h00;
    exp_d[1] = 8'h53;
    exp_d[2] = 8'h00;
    exp_d[3] = 8'h51;

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.cmd_rd_wr = 1'b0;
    bus.rsp_ready = 1'b1;
    cyc(3);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_level", bus.level, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_m_enable", bus.m_enable, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 0);
    chk("rst_m_bus", {bus.m_addr, bus.m_data, bus.m_rd_wr}, 0);
    rst = 1'b0;
    cyc(1);

    // Single write
    sb.push_back({1'b0, 8'h00});
    push(7'h50, 8'hA5, 1'b0, ok);
    wait_en(1'b1, "wr_en_rise");
    chk("wr_m_bus", {bus.m_addr, bus.m_data, bus.m_rd_wr},
        {7'h50, 8'hA5, 1'b0});
    wait_en(1'b0, "wr_en_fall");
    chk("wr_en_held_till_accept", bus.m_ready, 0);
    wait_idle("wr_drain");

    // Single read
    sb.push_back({1'b0, 8'h7E});
    push(7'h3C, 8'h00, 1'b1, ok);
    wait_idle("rd_drain");
    chk("rd_busy_low", bus.busy, 0);

    // Back-pressure: stalled response, FIFO fills, 5th refused
    bus.rsp_ready = 1'b0;
    sb.push_back({1'b0, 8'h00});
    push(7'h20, 8'h11, 1'b0, ok);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      cyc(1);
      n++;
    end
    chk("bp_first_rsp", bus.rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      push(7'h10 + 7'(i), 8'hC0 + 8'(i), i[0], ok);
      chk($sformatf("bp_accept%0d", i), ok, i < 4);
      if (i < 4) sb.push_back({1'b0, exp_d[i]});
    end
    chk("bp_level_full", bus.level, 4);
    chk("bp_cmd_ready", bus.cmd_ready, 0);
    chk("bp_stalled", bus.busy, 0);
    bus.rsp_ready = 1'b1;
    cyc(1);
    bus.rsp_ready = 1'b0;
    cyc(1);
    chk("bp_level_after_pop", bus.level, 3);
    chk("bp_busy_after_pop", bus.busy, 1);
    cyc(30);
    chk("bp_one_issued_rsp", bus.rsp_valid, 1);
    chk("bp_one_issued_level", bus.level, 3);
    bus.rsp_ready = 1'b1;
    wait_idle("bp_drain");

    // ISSUE timeout: master never accepts
    mode = 1;
    bus.rsp_ready = 1'b0;
    sb.push_back({1'b1, 8'h00});
    push(7'h61, 8'h22, 1'b0, ok);
    sb.push_back({1'b0, 8'h00});
    push(7'h62, 8'h33, 1'b0, ok);
    n = 0;
    while (bus.m_enable && n < 100) begin
      n++;
      cyc(1);
    end
    chk("to_issue_en_cycles", n, 16);
    chk("to_issue_rsp_valid", bus.rsp_valid, 1);
    chk("to_issue_queued", {bus.busy, bus.level}, {1'b0, 3'd1});
    mode = 0;
    bus.rsp_ready = 1'b1;
    wait_idle("to_issue_drain");

    // WAIT_DONE timeout: ready never returns
    mode = 2;
    sb.push_back({1'b1, 8'h00});
    push(7'h70, 8'h44, 1'b0, ok);
    wait_en(1'b1, "to_wait_en_rise");
    wait_en(1'b0, "to_wait_en_fall");
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      cyc(1);
      n++;
    end
    chk("to_wait_cycles", n, 16);
    wait_idle("to_wait_drain");
    mode = 0;
    cyc(4);

    // Reset in WAIT_DONE with two queued: no responses expected
    push(7'h01, 8'h01, 1'b0, ok);
    push(7'h02, 8'h02, 1'b0, ok);
    push(7'h03, 8'h03, 1'b1, ok);
    chk("rst_mid_level", bus.level, 2);
    wait_en(1'b0, "rst_mid_wait_done");
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_m_enable", bus.m_enable, 0);
    chk("rst_mid_level0", bus.level, 0);
    chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mid_cmd_ready", bus.cmd_ready, 1);
    chk("rst_mid_busy", bus.busy, 0);
    rst = 1'b0;
    cyc(20);
    chk("rst_mid_stays_idle", {bus.busy, bus.rsp_valid, bus.level}, 0);

    sb.push_back({1'b0, 8'h4D});
    push(7'h0F, 8'h5A, 1'b1, ok);
    wait_idle("recover_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
